// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared types, defaults and helpers for the button debounce block
package gpio_pkg;

    // Default channel count and debounce interval used by the GPIO button input path
    localparam int GPIO_NUM_BTN            = 4;
    localparam int GPIO_DEBOUNCE_CYCLES    = 50000;
    localparam int GPIO_SYNC_STAGES        = 2;

    // One bit per button channel
    typedef logic [GPIO_NUM_BTN-1:0] gpio_btn_t;

    // Counter width able to hold the values 0..cycles
    function automatic int deb_cnt_width(int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// rtl/gpio_debounce_ch.sv - one button channel: synchroniser, stability counter, stable level and edge pulses
module gpio_debounce_ch
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int               CNT_W    = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q;

    assign sync = sync_q[SYNC_STAGES-1];

    // Metastability chain: the raw pin enters at bit 0, the settled copy leaves at the top bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
        end
    end

    // Accept a new level only after it has been seen for DEBOUNCE_CYCLES consecutive cycles;
    // any return to the current stable level restarts the qualification from zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            stable_o <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (sync == stable_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q    <= '0;
                stable_o <= sync;
                rise_o   <= sync;
                fall_o   <= ~sync;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/gpio_button_debounce.sv
// rtl/gpio_button_debounce.sv - debounced button inputs with sticky press flags; GPIO_DEBOUNCE_IRQ_EN adds irq_o
module gpio_button_debounce
    import gpio_pkg::*;
#(
    parameter int NUM_BTN         = GPIO_NUM_BTN,
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] button_i,
    output logic [NUM_BTN-1:0] btn_stable_o,
    output logic [NUM_BTN-1:0] btn_rise_o,
    output logic [NUM_BTN-1:0] btn_fall_o,
    output logic [NUM_BTN-1:0] evt_o,
    input  logic [NUM_BTN-1:0] evt_clr_i
`ifdef GPIO_DEBOUNCE_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    // Channels are fully independent; each owns its synchroniser and counter
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        gpio_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .button_i (button_i[i]),
            .stable_o (btn_stable_o[i]),
            .rise_o   (btn_rise_o[i]),
            .fall_o   (btn_fall_o[i])
        );
    end

    // Sticky press flags: a press sets, write-1 clears, and a press in the clearing cycle wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_o <= '0;
        end else begin
            evt_o <= (evt_o & ~evt_clr_i) | btn_rise_o;
        end
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    // Level interrupt follows any pending flag one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |evt_o;
        end
    end
`endif

endmodule
